// File: rtl/apb_node_timeout.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : apb_node_timeout                                              |
// | Purpose  : APB 1-to-NB_SLV node with window decode, error on unmapped    |
// |            addresses and an optional access-phase watchdog enabled by    |
// |            the APB_NODE_TIMEOUT_EN macro.                                |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module apb_node_timeout #(
  parameter int                           NB_SLV         = 3,
  parameter int                           ADDR_WIDTH     = 32,
  parameter int                           DATA_WIDTH     = 32,
  parameter logic [NB_SLV*ADDR_WIDTH-1:0] START_ADDR     = {32'h2100_2000, 32'h2100_1000, 32'h2100_0000},
  parameter logic [NB_SLV*ADDR_WIDTH-1:0] END_ADDR       = {32'h2100_2FFF, 32'h2100_1FFF, 32'h2100_0FFF},
  parameter int                           TIMEOUT_CYCLES = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [ADDR_WIDTH-1:0]        s_paddr,
  input  logic [DATA_WIDTH-1:0]        s_pwdata,
  input  logic                         s_pwrite,
  input  logic                         s_psel,
  input  logic                         s_penable,
  output logic [DATA_WIDTH-1:0]        s_prdata,
  output logic                         s_pready,
  output logic                         s_pslverr,
  output logic [ADDR_WIDTH-1:0]        m_paddr,
  output logic [DATA_WIDTH-1:0]        m_pwdata,
  output logic                         m_pwrite,
  output logic [NB_SLV-1:0]            m_psel,
  output logic                         m_penable,
  input  logic [NB_SLV*DATA_WIDTH-1:0] m_prdata,
  input  logic [NB_SLV-1:0]            m_pready,
  input  logic [NB_SLV-1:0]            m_pslverr
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic                    r_pwrite;
  logic [NB_SLV-1:0]       r_sel;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_err;
  logic [NB_SLV-1:0]       w_hit;
  logic [NB_SLV-1:0]       w_sel;
  logic                    w_start;
  logic                    w_mrdy;
  logic [DATA_WIDTH-1:0]   w_mrdata;
  logic                    w_merr;
  logic                    w_expire;

  generate
    for (genvar gi = 0; gi < NB_SLV; gi++) begin : g_dec
      assign w_hit[gi] = (s_paddr >= START_ADDR[gi*ADDR_WIDTH +: ADDR_WIDTH]) &&
                         (s_paddr <= END_ADDR[gi*ADDR_WIDTH +: ADDR_WIDTH]);
    end
  endgenerate

  // Scan from the top so the lowest matching window is the last one written.
  always_comb begin
    w_sel = '0;
    for (int i = NB_SLV - 1; i >= 0; i--) begin
      if (w_hit[i]) w_sel = NB_SLV'(1) << i;
    end
  end

  always_comb begin
    w_mrdata = '0;
    w_merr   = 1'b0;
    for (int i = 0; i < NB_SLV; i++) begin
      if (r_sel[i]) begin
        w_mrdata = m_prdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_merr   = m_pslverr[i];
      end
    end
  end

  assign w_start = s_psel & ~s_penable;
  assign w_mrdy  = |(m_pready & r_sel);

`ifdef APB_NODE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == ST_SETUP) begin
      r_cnt <= '0;
    end else if (r_state == ST_ACCESS && !w_mrdy) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Fires on the access cycle whose missed ready brings the count to the limit.
  assign w_expire = (r_state == ST_ACCESS) && !w_mrdy &&
                    (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_expire = 1'b0;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_start) w_next = (|w_sel) ? ST_SETUP : ST_ERR;
      ST_SETUP:  w_next = ST_ACCESS;
      ST_ACCESS: if (w_mrdy || w_expire) w_next = ST_DONE;
      ST_DONE:   w_next = ST_IDLE;
      ST_ERR:    w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pwrite <= 1'b0;
      r_sel    <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && w_start) begin
        r_paddr  <= s_paddr;
        r_pwdata <= s_pwdata;
        r_pwrite <= s_pwrite;
        r_sel    <= w_sel;
      end
      if (r_state == ST_ACCESS) begin
        if (w_mrdy) begin
          r_rdata <= w_mrdata;
          r_err   <= w_merr;
        end else if (w_expire) begin
          r_rdata <= '0;
          r_err   <= 1'b1;
        end
      end
    end
  end

  assign m_paddr   = r_paddr;
  assign m_pwdata  = r_pwdata;
  assign m_pwrite  = r_pwrite;
  assign m_psel    = (r_state == ST_SETUP || r_state == ST_ACCESS) ? r_sel : '0;
  assign m_penable = (r_state == ST_ACCESS);
  assign s_pready  = (r_state == ST_DONE) || (r_state == ST_ERR);
  assign s_pslverr = (r_state == ST_ERR) || ((r_state == ST_DONE) && r_err);
  assign s_prdata  = (r_state == ST_DONE) ? r_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_apb_node_timeout.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_apb_node_timeout                                           |
// | Purpose  : Directed vector bench for apb_node_timeout; hang test adapts  |
// |            to the APB_NODE_TIMEOUT_EN macro.                             |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_apb_node_timeout;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_paddr, s_pwdata, s_prdata;
  logic        s_pwrite, s_psel, s_penable, s_pready, s_pslverr;
  logic [31:0] m_paddr, m_pwdata;
  logic        m_pwrite, m_penable;
  logic [2:0]  m_psel, m_pready, m_pslverr;
  logic [95:0] m_prdata;

  apb_node_timeout #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata), .s_pwrite(s_pwrite),
    .s_psel(s_psel), .s_penable(s_penable),
    .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata), .m_pwrite(m_pwrite),
    .m_psel(m_psel), .m_penable(m_penable),
    .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    int          slv;
    int          wt;
    logic [31:0] rdata;
    logic        err;
    logic [2:0]  esel;
    logic [31:0] erdata;
    logic        eerr;
    int          elat;
  } vec_t;

  vec_t vecs[8];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input vec_t v, input string tag);
    int acc  = 0;
    bit seen = 0;
    s_paddr   = v.addr;
    s_pwdata  = v.wdata;
    s_pwrite  = v.wr;
    s_psel    = 1'b1;
    s_penable = 1'b0;
    m_pready  = '0;
    m_pslverr = '0;
    m_prdata  = {3{32'hBAD0_BAD0}};
    m_prdata[v.slv*32 +: 32] = v.rdata;
    for (int t = 1; t <= 200 && !seen; t++) begin
      step();
      if (t == 1) begin
        chk({tag, "/sel_setup"}, m_psel, v.esel);
        if (v.esel != 3'b000) begin
          chk({tag, "/penable_setup"}, m_penable, 1'b0);
          chk({tag, "/paddr"}, m_paddr, v.addr);
          chk({tag, "/pwrite"}, m_pwrite, v.wr);
          if (v.wr) chk({tag, "/pwdata"}, m_pwdata, v.wdata);
        end
        s_penable = 1'b1;
        s_paddr   = ~v.addr;
        s_pwdata  = ~v.wdata;
        s_pwrite  = ~v.wr;
      end
      if (t == 2 && v.esel != 3'b000) begin
        chk({tag, "/sel_access"}, m_psel, v.esel);
        chk({tag, "/penable_access"}, m_penable, 1'b1);
        chk({tag, "/paddr_held"}, m_paddr, v.addr);
      end
      if (m_penable) acc++;
      if (s_pready) begin
        seen = 1;
        chk({tag, "/latency"}, t, v.elat);
        chk({tag, "/prdata"}, s_prdata, v.erdata);
        chk({tag, "/pslverr"}, s_pslverr, v.eerr);
        chk({tag, "/sel_done"}, {m_psel, m_penable}, 4'b0000);
      end
      m_pready  = '0;
      m_pslverr = '0;
      if (m_penable && acc > v.wt) begin
        m_pready[v.slv]  = 1'b1;
        m_pslverr[v.slv] = v.err;
      end
    end
    if (!seen) chk({tag, "/no_response"}, 1'b0, 1'b1);
    step();
    s_psel    = 1'b0;
    s_penable = 1'b0;
    m_pready  = '0;
    m_pslverr = '0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    int  acc;
    bit  seen;
    vec_t v;

    //          addr          wdata         wr  slv wt rdata         err esel    erdata        eerr lat
    vecs[0] = '{32'h2100_1004, 32'h0,       0,  1,  0, 32'hDEAD_BEEF, 0, 3'b010, 32'hDEAD_BEEF, 0,   3};
    vecs[1] = '{32'h2100_0FFF, 32'h1234,    1,  0,  0, 32'h0,         0, 3'b001, 32'h0,         0,   3};
    vecs[2] = '{32'h2100_3000, 32'h55,      1,  0,  0, 32'h0,         0, 3'b000, 32'h0,         1,   1};
    vecs[3] = '{32'h2100_2000, 32'h0,       0,  2,  5, 32'hCAFE_0002, 1, 3'b100, 32'hCAFE_0002, 1,   8};
    vecs[4] = '{32'h2100_0000, 32'h0,       0,  0,  0, 32'h0000_5A5A, 0, 3'b001, 32'h0000_5A5A, 0,   3};
    vecs[5] = '{32'h2100_2FFF, 32'h0,       0,  2,  0, 32'h0000_A5A5, 0, 3'b100, 32'h0000_A5A5, 0,   3};
    vecs[6] = '{32'h20FF_FFFF, 32'h0,       0,  0,  0, 32'h0,         0, 3'b000, 32'h0,         1,   1};
    vecs[7] = '{32'h2100_1FFF, 32'h9,       1,  1,  2, 32'h1111_0000, 0, 3'b010, 32'h1111_0000, 0,   5};

    rst = 1'b1;
    s_paddr = '0; s_pwdata = '0; s_pwrite = 1'b0; s_psel = 1'b0; s_penable = 1'b0;
    m_prdata = '0; m_pready = '0; m_pslverr = '0;
    step();
    step();
    chk("reset/m_bus", {m_psel, m_penable, m_pwrite, m_paddr, m_pwdata}, 69'h0);
    chk("reset/s_resp", {s_pready, s_pslverr, s_prdata}, 34'h0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 8; i++) xfer(vecs[i], $sformatf("vec%0d", i));

    // Enable high while idle is a protocol violation and must not start anything.
    s_paddr = 32'h2100_0010; s_psel = 1'b1; s_penable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("penable_idle%0d", i), {m_psel, s_pready}, 4'b0000);
    end
    s_psel = 1'b0; s_penable = 1'b0;
    step();

    // Slave 0 never answers.
    s_paddr = 32'h2100_0000; s_pwrite = 1'b0; s_psel = 1'b1; s_penable = 1'b0;
    m_prdata = {3{32'hFFFF_FFFF}};
    acc = 0; seen = 0;
`ifdef APB_NODE_TIMEOUT_EN
    for (int t = 1; t <= 100 && !seen; t++) begin
      step();
      if (t == 1) s_penable = 1'b1;
      if (m_penable) acc++;
      if (s_pready) begin
        seen = 1;
        chk("tmo/access_cycles", acc, 16);
        chk("tmo/pslverr", s_pslverr, 1'b1);
        chk("tmo/prdata", s_prdata, 32'h0);
        chk("tmo/sel_after", {m_psel, m_penable}, 4'b0000);
      end
    end
    chk("tmo/responded", seen, 1'b1);
    step();
`else
    for (int t = 1; t <= 1000; t++) begin
      step();
      if (t == 1) s_penable = 1'b1;
      if (s_pready) seen = 1;
    end
    chk("hang/no_response", seen, 1'b0);
    chk("hang/still_access", {m_psel, m_penable}, 4'b0011);
    m_prdata[31:0] = 32'h0000_0077;
    m_pready = 3'b001;
    step();
    chk("hang/release_ready", {s_pready, s_pslverr}, 2'b10);
    chk("hang/release_data", s_prdata, 32'h0000_0077);
    step();
`endif
    s_psel = 1'b0; s_penable = 1'b0; m_pready = '0;

    // Reset in the middle of an access phase drops the transfer.
    s_paddr = 32'h2100_1004; s_psel = 1'b1; s_penable = 1'b0;
    step();
    s_penable = 1'b1;
    step();
    chk("rstmid/in_access", {m_psel, m_penable}, 4'b0101);
    rst = 1'b1; s_psel = 1'b0; s_penable = 1'b0;
    step();
    chk("rstmid/after", {m_psel, m_penable, s_pready}, 5'b00000);
    rst = 1'b0;
    v = '{32'h2100_2000, 32'h0, 0, 2, 0, 32'h2468_ACE0, 0, 3'b100, 32'h2468_ACE0, 0, 3};
    xfer(v, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
